fft_result_sink: RTL

Avalon-MM write-slave that terminates the write stream issued by the FFT engine's `custom_master_slave` master port. It accepts one frame of `FRAME_LEN` result words, buffers them in a small FIFO and back-pressures the master through `slave_waitrequest`. It re-emits the words on a valid/ready stream with an end-of-frame marker and signals frame completion. It sits directly downstream of the FFT master and feeds the result consumer (DMA/output formatter).

---
 rtl/fft_sink_pkg.sv | 15 +
 rtl/fft_result_sink_if.sv | 32 +++
 rtl/sink_fifo.sv | 65 ++++++
 rtl/fft_result_sink.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fft_sink_pkg.sv
// fft_sink_pkg: shared types and status-word field positions for fft_result_sink.
package fft_sink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } sink_state_t;

    localparam int unsigned STAT_SEQ_ERR_BIT = 16;
    localparam int unsigned STAT_BUSY_BIT    = 17;
    localparam int unsigned STAT_LEVEL_LSB   = 24;
    localparam int unsigned STAT_LEVEL_W     = 8;

endpackage

// File: rtl/fft_result_sink_if.sv
// fft_result_sink_if: Avalon-MM write/status port plus result stream of the FFT result sink.
interface fft_result_sink_if #(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned ADDRESSWIDTH = 9
);
    logic [ADDRESSWIDTH-1:0] slave_address;
    logic                    slave_write;
    logic [DATAWIDTH-1:0]    slave_writedata;
    logic                    slave_waitrequest;
    logic                    slave_read;
    logic [DATAWIDTH-1:0]    slave_readdata;
    logic                    slave_readdatavalid;
    logic [DATAWIDTH-1:0]    out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    frame_done;

    // Environment side: FFT master plus downstream consumer.
    modport master (
        output slave_address, slave_write, slave_writedata, slave_read, out_ready,
        input  slave_waitrequest, slave_readdata, slave_readdatavalid,
        input  out_data, out_valid, out_last, frame_done
    );

    // Sink side.
    modport slave (
        input  slave_address, slave_write, slave_writedata, slave_read, out_ready,
        output slave_waitrequest, slave_readdata, slave_readdatavalid,
        output out_data, out_valid, out_last, frame_done
    );
endinterface

// File: rtl/sink_fifo.sv
// sink_fifo: synchronous FIFO with flop storage; head word read directly from storage registers.
module sink_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    // A full FIFO never takes a push, even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fft_result_sink.sv
// fft_result_sink: terminates the FFT master's write stream, buffers one frame through a FIFO
// and re-emits it as a valid/ready stream with end-of-frame tag and completion pulse.
// Optional status readback and address-sequence checking: define FFT_SINK_STATUS_EN.
module fft_result_sink #(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned ADDRESSWIDTH = 9,
    parameter int unsigned FRAME_LEN    = 512,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    fft_result_sink_if.slave  bus
);
    import fft_sink_pkg::*;

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDRESSWIDTH-1:0] LAST_IDX = ADDRESSWIDTH'(FRAME_LEN - 1);

    sink_state_t             state;
    sink_state_t             state_n;
    logic [ADDRESSWIDTH-1:0] idx;
    logic [ADDRESSWIDTH-1:0] idx_n;
    logic                    push_last;
    logic                    accept;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [LW-1:0]           level;
    logic [DATAWIDTH:0]      head;
    logic                    head_last;
    logic                    frame_done_q;

    assign bus.slave_waitrequest = bus.slave_write && (fifo_full || (state == DRAIN));
    assign accept    = bus.slave_write && !bus.slave_waitrequest;
    assign head_last = head[DATAWIDTH];
    assign pop       = !fifo_empty && bus.out_ready;

    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = head[DATAWIDTH-1:0];
    assign bus.out_last   = !fifo_empty && head_last;
    assign bus.frame_done = frame_done_q;

    sink_fifo #(
        .WIDTH (DATAWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push    (accept),
        .wr_data ({push_last, bus.slave_writedata}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Frame sequencing: word index advance, last tagging and state transitions.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        push_last = (idx == LAST_IDX);
        unique case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    idx_n   = push_last ? '0 : idx + ADDRESSWIDTH'(1);
                    state_n = push_last ? DRAIN : COLLECT;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, index and completion-pulse registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            idx          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            frame_done_q <= pop && head_last;
        end
    end

`ifdef FFT_SINK_STATUS_EN
    logic                 seq_err;
    logic                 seq_err_n;
    logic [DATAWIDTH-1:0] status;
    logic [DATAWIDTH-1:0] rdata_q;
    logic                 rvalid_q;

    // The first write of a frame starts a fresh error record; later writes accumulate.
    always_comb begin
        seq_err_n = seq_err;
        if (accept) begin
            seq_err_n = ((state == COLLECT) && seq_err) || (bus.slave_address != idx);
        end
    end

    // Status word assembled from current registered state.
    always_comb begin
        status                                    = '0;
        status[ADDRESSWIDTH-1:0]                  = idx;
        status[STAT_SEQ_ERR_BIT]                  = seq_err;
        status[STAT_BUSY_BIT]                     = (state != IDLE);
        status[STAT_LEVEL_LSB +: STAT_LEVEL_W]    = STAT_LEVEL_W'(level);
    end

    // Sticky sequence error and one-cycle-latency status read response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            seq_err  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            seq_err  <= seq_err_n;
            rvalid_q <= bus.slave_read;
            if (bus.slave_read) begin
                rdata_q <= status;
            end
        end
    end

    assign bus.slave_readdata      = rdata_q;
    assign bus.slave_readdatavalid = rvalid_q;
`else
    logic unused_status;

    assign bus.slave_readdata      = '0;
    assign bus.slave_readdatavalid = 1'b0;
    assign unused_status           = &{1'b0, bus.slave_read, bus.slave_address, level};
`endif
endmodule
